uart_tx_fifo: RTL and testbench

- Buffered byte feeder in front of uart_tx: accepts bytes from any producer (uart_rx echo path, CPU I/O port) through a single-cycle write strobe.
- Stores bytes in a DEPTH-entry FIFO and drains them one at a time into uart_tx using the tx_start/tx_busy handshake.
- Replaces hand-written per-design transmit state machines; allows back-to-back writes without waiting on the serial line.

---
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a uart_tx through a tx_start/tx_busy
// handshake. Producers push one byte per cycle with wr_en; the drain FSM pops
// the head entry whenever the transmitter is idle and issues a one-cycle start.
//
// Handshakes:
//   write side: wr_en is a one-cycle valid with no ready. The producer is
//     expected to watch full; a write seen while full (as registered at the
//     start of the cycle) is dropped and latches the sticky overflow flag.
//   transmit side: tx_data is loaded on a pop and tx_start is high for the
//     following single cycle. The transmitter acknowledges by raising tx_busy;
//     the byte is done when tx_busy falls. If tx_busy never rises within
//     ACK_TIMEOUT cycles, the byte is treated as sent so the FSM cannot hang.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q;
  logic            overflow_q, overflow_d;
  logic            tx_start_q;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_accept;
  logic            pop;

  // Full is taken from the registered flag, so a pop in the same cycle never
  // makes room for a write that arrived while the FIFO was full.
  assign wr_accept = wr_en && !full_q;

  // Storage array; contents are not reset because count/pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, occupancy and overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr_accept && pop) begin
      count_d = count_q - CW'(1);
    end
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end
  end

  // Drain FSM next-state: pop when idle and the transmitter is free.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pop       = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (!empty_q && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_d == TW'(ACK_TIMEOUT)) begin
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset flushes the FIFO and idles the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      tx_start_q <= (state_d == START);
      tx_data_q  <= tx_data_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural uart_tx busy model, a scoreboard of
// expected transmitted bytes, and one task per scenario.
module tb_uart_tx_fifo;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 4;
  localparam int CW          = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, overflow, tx_start, tx_busy;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;
  logic [1:0]    state_o;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;

  logic [7:0] exp_q[$];

  // uart_tx stand-in: busy rises the cycle after tx_start and lasts busy_len cycles.
  logic busy_force = 1'b0;
  logic model_en   = 1'b0;
  logic busy_model = 1'b0;
  int   busy_len   = 20;
  int   busy_left  = 0;

  assign tx_busy = busy_force | busy_model;

  uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .state_o  (state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Busy model
  always @(posedge clk) begin
    if (tx_start && model_en) begin
      busy_model <= 1'b1;
      busy_left  <= busy_len - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_model <= 1'b0;
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  logic [7:0] prev_data  = 8'h00;
  logic       prev_start = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [7:0] exp_byte;
  always @(negedge clk) begin
    if (tx_start) begin
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_start: tx_data=%h, no byte expected", tx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        if (tx_data !== exp_byte) begin
          failures++;
          $display("FAIL sb_tx_data: got %h, expected %h", tx_data, exp_byte);
        end
      end
      checks++;
      if (prev_start) begin
        failures++;
        $display("FAIL start_twice: tx_start high two cycles in a row");
      end
      checks++;
      if (tx_busy !== 1'b0) begin
        failures++;
        $display("FAIL start_while_busy: tx_busy=%b, expected 0", tx_busy);
      end
    end else if (!rst && !prev_rst) begin
      checks++;
      if (tx_data !== prev_data) begin
        failures++;
        $display("FAIL data_unstable: tx_data %h changed from %h without a pop", tx_data, prev_data);
      end
    end
    prev_data  = tx_data;
    prev_start = tx_start;
    prev_rst   = rst;
  end

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_tx);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_tx) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk);
      #1;
      if (state_o == 2'd0 && empty && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL rst_empty: got %b, expected 1", empty); end
    checks++; if (full !== 1'b0)     begin failures++; $display("FAIL rst_full: got %b, expected 0", full); end
    checks++; if (count !== '0)      begin failures++; $display("FAIL rst_count: got %0d, expected 0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b, expected 0", overflow); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start: got %b, expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h, expected 00", tx_data); end
    checks++; if (state_o !== 2'd0)  begin failures++; $display("FAIL rst_state: got %0d, expected 0", state_o); end
  endtask

  task automatic test_single();
    bit ok;
    model_en = 1'b1;
    busy_len = 20;
    write_byte(8'h41, 1'b1);
    checks++; if (count !== CW'(1))  begin failures++; $display("FAIL single_count_k: got %0d, expected 1", count); end
    checks++; if (empty !== 1'b0)    begin failures++; $display("FAIL single_empty_k: got %b, expected 0", empty); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_k: got %b, expected 0", tx_start); end
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start_k1: got %b, expected 1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin failures++; $display("FAIL single_data_k1: got %h, expected 41", tx_data); end
    checks++; if (count !== '0)      begin failures++; $display("FAIL single_count_k1: got %0d, expected 0", count); end
    checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL single_empty_k1: got %b, expected 1", empty); end
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_k2: got %b, expected 0", tx_start); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain: state=%0d busy=%b, expected idle", state_o, tx_busy); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_sb_left: %0d bytes, expected 0", exp_q.size()); end
  endtask

  task automatic test_burst();
    bit ok;
    model_en = 1'b1;
    busy_len = 20;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h30 + i), 1'b1);
    // One byte has left for uart_tx; the rest wait behind the 20-cycle frame.
    checks++; if (count !== CW'(15))  begin failures++; $display("FAIL burst_count: got %0d, expected 15", count); end
    checks++; if (full !== 1'b0)      begin failures++; $display("FAIL burst_full: got %b, expected 0", full); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL burst_overflow: got %b, expected 0", overflow); end
    wait_idle(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_drain: state=%0d count=%0d, expected idle", state_o, count); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL burst_sb_left: %0d bytes, expected 0", exp_q.size()); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL burst_overflow_end: got %b, expected 0", overflow); end
  endtask

  task automatic test_overflow();
    bit ok;
    int s0;
    model_en   = 1'b1;
    busy_len   = 3;
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h50 + i), 1'b1);
    checks++; if (full !== 1'b1)      begin failures++; $display("FAIL ovf_full16: got %b, expected 1", full); end
    checks++; if (count !== CW'(16))  begin failures++; $display("FAIL ovf_count16: got %0d, expected 16", count); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL ovf_flag16: got %b, expected 0", overflow); end
    write_byte(8'h60, 1'b0);
    checks++; if (count !== CW'(16))  begin failures++; $display("FAIL ovf_count17: got %0d, expected 16", count); end
    checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL ovf_flag17: got %b, expected 1", overflow); end
    // Release busy and write while still full: the pop must not admit this write.
    s0 = start_cnt;
    busy_force = 1'b0;
    write_byte(8'h61, 1'b0);
    checks++; if (tx_start !== 1'b1)  begin failures++; $display("FAIL ovf_pop_start: got %b, expected 1", tx_start); end
    checks++; if (count !== CW'(15))  begin failures++; $display("FAIL ovf_pop_count: got %0d, expected 15", count); end
    checks++; if (full !== 1'b0)      begin failures++; $display("FAIL ovf_pop_full: got %b, expected 0", full); end
    wait_idle(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_drain: state=%0d count=%0d, expected idle", state_o, count); end
    checks++; if (start_cnt - s0 != 16) begin failures++; $display("FAIL ovf_pulses: got %0d, expected 16", start_cnt - s0); end
    checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
    checks++; if (exp_q.size() != 0)  begin failures++; $display("FAIL ovf_sb_left: %0d bytes, expected 0", exp_q.size()); end
  endtask

  task automatic test_simul();
    bit ok;
    model_en   = 1'b1;
    busy_len   = 5;
    busy_force = 1'b1;
    write_byte(8'h70, 1'b1);
    checks++; if (count !== CW'(1)) begin failures++; $display("FAIL simul_pre_count: got %0d, expected 1", count); end
    busy_force = 1'b0;
    write_byte(8'h71, 1'b1);
    checks++; if (count !== CW'(1))  begin failures++; $display("FAIL simul_count: got %0d, expected 1", count); end
    checks++; if (empty !== 1'b0)    begin failures++; $display("FAIL simul_empty: got %b, expected 0", empty); end
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL simul_start: got %b, expected 1", tx_start); end
    checks++; if (tx_data !== 8'h70) begin failures++; $display("FAIL simul_data: got %h, expected 70", tx_data); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL simul_drain: state=%0d count=%0d, expected idle", state_o, count); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL simul_sb_left: %0d bytes, expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int t[$];
    model_en   = 1'b0;
    busy_force = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) begin
        wr_en   = 1'b1;
        wr_data = 8'(8'hC0 + c);
        exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
      if (tx_start) t.push_back(c);
    end
    wr_en = 1'b0;
    checks++;
    if (t.size() != 3) begin
      failures++; $display("FAIL timeout_pulses: got %0d, expected 3", t.size());
    end else begin
      // START (1) + WAIT_ACK (ACK_TIMEOUT) + IDLE pop (1) between pulses.
      checks++; if (t[1] - t[0] != ACK_TIMEOUT + 2) begin failures++; $display("FAIL timeout_gap1: got %0d, expected %0d", t[1] - t[0], ACK_TIMEOUT + 2); end
      checks++; if (t[2] - t[1] != ACK_TIMEOUT + 2) begin failures++; $display("FAIL timeout_gap2: got %0d, expected %0d", t[2] - t[1], ACK_TIMEOUT + 2); end
    end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL timeout_idle: got %0d, expected 0", state_o); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL timeout_sb_left: %0d bytes, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit reached;
    bit early;
    model_en   = 1'b1;
    busy_len   = 20;
    busy_force = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'(8'hD0 + i), 1'b1);
    reached = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (state_o == 2'd3) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!reached) begin failures++; $display("FAIL mid_wait_done: state=%0d, expected 3", state_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    checks++; if (count !== '0)      begin failures++; $display("FAIL mid_count: got %0d, expected 0", count); end
    checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL mid_empty: got %b, expected 1", empty); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_start: got %b, expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_data: got %h, expected 00", tx_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow: got %b, expected 0", overflow); end
    checks++; if (state_o !== 2'd0)  begin failures++; $display("FAIL mid_state: got %0d, expected 0", state_o); end
    write_byte(8'hE0, 1'b1);
    early = 1'b0;
    for (int c = 0; c < 40 && tx_busy; c++) begin
      if (tx_start) early = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (early) begin failures++; $display("FAIL mid_early_start: tx_start seen while busy, expected none"); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL mid_busy_bound: busy=%b, expected 0 by now", tx_busy); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_drain: state=%0d count=%0d, expected idle", state_o, count); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mid_sb_left: %0d bytes, expected 0", exp_q.size()); end
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
